// File: rtl/z80_pkg.sv
// Shared Z80 definitions: flag bit positions, condition codes, CALL opcodes
// and the state encoding of the CALL execution unit.
package z80_pkg;

  localparam int FLAG_S_NUM  = 7;
  localparam int FLAG_Z_NUM  = 6;
  localparam int FLAG_PV_NUM = 2;
  localparam int FLAG_C_NUM  = 0;

  localparam logic [2:0] CC_NZ = 3'd0;
  localparam logic [2:0] CC_Z  = 3'd1;
  localparam logic [2:0] CC_NC = 3'd2;
  localparam logic [2:0] CC_C  = 3'd3;
  localparam logic [2:0] CC_PO = 3'd4;
  localparam logic [2:0] CC_PE = 3'd5;
  localparam logic [2:0] CC_P  = 3'd6;
  localparam logic [2:0] CC_M  = 3'd7;

  localparam logic [7:0] OPC_CALL_NN      = 8'hCD;
  localparam logic [7:0] OPC_CALL_CC_MASK = 8'hC7;
  localparam logic [7:0] OPC_CALL_CC_BASE = 8'hC4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_LO = 3'd1,
    ST_RD_HI = 3'd2,
    ST_WR_HI = 3'd3,
    ST_WR_LO = 3'd4,
    ST_FIN   = 3'd5
  } call_state_t;

  function automatic logic is_call_opcode(input logic [7:0] op);
    return (op == OPC_CALL_NN) || ((op & OPC_CALL_CC_MASK) == OPC_CALL_CC_BASE);
  endfunction

endpackage

// File: rtl/z80_cond_eval.sv
// Combinational condition-code evaluator shared by the CALL cc, JP cc and
// RET cc paths: picks the flag for cond[2:1] and compares it with cond[0].
module z80_cond_eval
  import z80_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [7:0] f,
  output logic       met
);

  logic flag_bit;
  logic unused_flags;

  assign unused_flags = ^{f[5:3], f[1]};

  always_comb begin
    flag_bit = 1'b0;
    case (cond[2:1])
      2'd0:    flag_bit = f[FLAG_Z_NUM];
      2'd1:    flag_bit = f[FLAG_C_NUM];
      2'd2:    flag_bit = f[FLAG_PV_NUM];
      default: flag_bit = f[FLAG_S_NUM];
    endcase
    met = (flag_bit == cond[0]);
  end

endmodule

// File: rtl/z80_call_cond_exec.sv
// CALL nn / CALL cc,nn execution unit: fetches the target, evaluates the
// condition and, when taken, pushes the return address high byte first.
module z80_call_cond_exec
  import z80_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  opcode,
  input  logic [15:0] ip_in,
  input  logic [15:0] sp_in,
  input  logic [7:0]  f_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic        busy,
  output logic        done,
  output logic        taken,
  output logic        illegal,
  output logic [15:0] ip_out,
  output logic [15:0] sp_out
);

  call_state_t state_q, state_d;
  logic [7:0]  opcode_q, opcode_d;
  logic [15:0] ip_q, ip_d;
  logic [15:0] sp_q, sp_d;
  logic [7:0]  f_q, f_d;
  logic [15:0] ret_q, ret_d;
  logic [15:0] nn_q, nn_d;

  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        taken_q, taken_d;
  logic        illegal_q, illegal_d;
  logic [15:0] ip_out_q, ip_out_d;
  logic [15:0] sp_out_q, sp_out_d;

  logic        cond_met;
  logic        call_met;
  logic        xfer;

  z80_cond_eval u_cond_eval (
    .cond (opcode_q[5:3]),
    .f    (f_q),
    .met  (cond_met)
  );

  assign call_met = (opcode_q == OPC_CALL_NN) || cond_met;
  assign xfer     = mem_req_q && mem_ack;

  // Bus outputs are computed for the state being entered so that each new
  // request appears in the cycle right after the previous acknowledge.
  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    ip_d        = ip_q;
    sp_d        = sp_q;
    f_d         = f_q;
    ret_d       = ret_q;
    nn_d        = nn_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = 1'b0;
    taken_d     = taken_q;
    illegal_d   = illegal_q;
    ip_out_d    = ip_out_q;
    sp_out_d    = sp_out_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          opcode_d = opcode;
          ip_d     = ip_in;
          sp_d     = sp_in;
          f_d      = f_in;
          ret_d    = ip_in + 16'd3;
          if (is_call_opcode(opcode)) begin
            state_d    = ST_RD_LO;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = ip_in + 16'd1;
          end else begin
            state_d   = ST_FIN;
            done_d    = 1'b1;
            illegal_d = 1'b1;
            taken_d   = 1'b0;
            ip_out_d  = ip_in;
            sp_out_d  = sp_in;
          end
        end
      end
      ST_RD_LO: begin
        if (xfer) begin
          nn_d       = {nn_q[15:8], mem_rdata};
          state_d    = ST_RD_HI;
          mem_addr_d = ip_q + 16'd2;
        end
      end
      ST_RD_HI: begin
        if (xfer) begin
          nn_d = {mem_rdata, nn_q[7:0]};
          if (call_met) begin
            state_d     = ST_WR_HI;
            mem_we_d    = 1'b1;
            mem_addr_d  = sp_q - 16'd1;
            mem_wdata_d = ret_q[15:8];
          end else begin
            state_d   = ST_FIN;
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
            done_d    = 1'b1;
            taken_d   = 1'b0;
            illegal_d = 1'b0;
            ip_out_d  = ret_q;
            sp_out_d  = sp_q;
          end
        end
      end
      ST_WR_HI: begin
        if (xfer) begin
          state_d     = ST_WR_LO;
          mem_addr_d  = sp_q - 16'd2;
          mem_wdata_d = ret_q[7:0];
        end
      end
      ST_WR_LO: begin
        if (xfer) begin
          state_d   = ST_FIN;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          done_d    = 1'b1;
          taken_d   = 1'b1;
          illegal_d = 1'b0;
          ip_out_d  = nn_q;
          sp_out_d  = sp_q - 16'd2;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      opcode_q    <= 8'h00;
      ip_q        <= 16'h0000;
      sp_q        <= 16'h0000;
      f_q         <= 8'h00;
      ret_q       <= 16'h0000;
      nn_q        <= 16'h0000;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 8'h00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      taken_q     <= 1'b0;
      illegal_q   <= 1'b0;
      ip_out_q    <= 16'h0000;
      sp_out_q    <= 16'h0000;
    end else begin
      state_q     <= state_d;
      opcode_q    <= opcode_d;
      ip_q        <= ip_d;
      sp_q        <= sp_d;
      f_q         <= f_d;
      ret_q       <= ret_d;
      nn_q        <= nn_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      taken_q     <= taken_d;
      illegal_q   <= illegal_d;
      ip_out_q    <= ip_out_d;
      sp_out_q    <= sp_out_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign taken     = taken_q;
  assign illegal   = illegal_q;
  assign ip_out    = ip_out_q;
  assign sp_out    = sp_out_q;

endmodule

// File: tb/tb_z80_call_cond_exec.sv
// Directed bench for z80_call_cond_exec: a simple memory responder with
// programmable wait states logs every bus transfer for checking.
module tb_z80_call_cond_exec;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [7:0]  opcode;
  logic [15:0] ip_in;
  logic [15:0] sp_in;
  logic [7:0]  f_in;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack = 1'b0;
  logic        busy;
  logic        done;
  logic        taken;
  logic        illegal;
  logic [15:0] ip_out;
  logic [15:0] sp_out;

  always #5 clk = ~clk;

  z80_call_cond_exec dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .opcode    (opcode),
    .ip_in     (ip_in),
    .sp_in     (sp_in),
    .f_in      (f_in),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .busy      (busy),
    .done      (done),
    .taken     (taken),
    .illegal   (illegal),
    .ip_out    (ip_out),
    .sp_out    (sp_out)
  );

  logic [7:0] mem [0:65535];
  assign mem_rdata = mem[mem_addr];

  int          wait_states = 0;
  int          wcnt = 0;
  int          log_n = 0;
  logic        log_we   [0:511];
  logic [15:0] log_addr [0:511];
  logic [7:0]  log_data [0:511];

  // Responder: logs each completed transfer, then decides ack for the next edge.
  always @(posedge clk) begin
    if (reset_n && mem_req && mem_ack) begin
      log_we[log_n]   = mem_we;
      log_addr[log_n] = mem_addr;
      log_data[log_n] = mem_we ? mem_wdata : mem_rdata;
      $display("xfer %0d: %s addr=%04h data=%02h", log_n, mem_we ? "WR" : "RD",
               mem_addr, mem_we ? mem_wdata : mem_rdata);
      log_n = log_n + 1;
      wcnt  = 0;
    end
    #1;
    if (!mem_req) begin
      mem_ack = 1'b0;
      wcnt    = 0;
    end else if (wcnt >= wait_states) begin
      mem_ack = 1'b1;
    end else begin
      mem_ack = 1'b0;
      wcnt    = wcnt + 1;
    end
  end

  int nchk  = 0;
  int nfail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk = nchk + 1;
    assert (obs === exp) else begin
      nfail = nfail + 1;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_xfer(input string tag, input int idx, input logic we,
                          input logic [15:0] a, input logic [7:0] d);
    check({tag, "_we"},   log_we[idx],   we);
    check({tag, "_addr"}, log_addr[idx], a);
    check({tag, "_data"}, log_data[idx], d);
  endtask

  task automatic run_call(input logic [7:0] op, input logic [15:0] ip, input logic [15:0] sp,
                          input logic [7:0] f, input int ws, input bit poke,
                          output int lat, output int base);
    int          cyc;
    bit          prev_req;
    int          prev_n;
    logic [15:0] prev_addr;
    logic [7:0]  prev_wdata;
    wait_states = ws;
    base = log_n;
    @(negedge clk);
    opcode = op; ip_in = ip; sp_in = sp; f_in = f; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    f_in  = ~f;
    cyc = 1; prev_req = 1'b0; prev_n = log_n; prev_addr = 16'h0; prev_wdata = 8'h0;
    while (!done && cyc < 200) begin
      if (prev_req && mem_req && log_n == prev_n) begin
        check("addr_stable", mem_addr, prev_addr);
        check("wdata_stable", mem_wdata, prev_wdata);
      end
      prev_req = mem_req; prev_n = log_n; prev_addr = mem_addr; prev_wdata = mem_wdata;
      if (poke && cyc == 4) begin
        start = 1'b1; opcode = 8'h00; ip_in = 16'hDEAD;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc = cyc + 1;
    end
    start = 1'b0;
    check("done_seen", done, 1'b1);
    lat = cyc;
    $display("call op=%02h ip=%04h sp=%04h f=%02h: lat=%0d taken=%b illegal=%b ip_out=%04h sp_out=%04h",
             op, ip, sp, f, lat, taken, illegal, ip_out, sp_out);
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
    check("busy_idle", busy, 1'b0);
  endtask

  int         lat;
  int         base;
  int         cyc;
  logic [7:0] op;
  logic [7:0] fv;
  logic [7:0] tk_00 = 8'h55;
  logic [7:0] tk_c5 = 8'hAA;
  logic       exp_tk;

  initial begin
    reset_n = 1'b0; start = 1'b0; opcode = 8'h00;
    ip_in = 16'h0; sp_in = 16'h0; f_in = 8'h0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h1001] = 8'h34; mem[16'h1002] = 8'h12;
    mem[16'hFFFF] = 8'hAA; mem[16'h0000] = 8'h55;
    mem[16'h2001] = 8'h78; mem[16'h2002] = 8'h56;

    repeat (3) @(negedge clk);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 16'h0);
    check("rst_mem_wdata", mem_wdata, 8'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_taken", taken, 1'b0);
    check("rst_illegal", illegal, 1'b0);
    check("rst_ip_out", ip_out, 16'h0);
    check("rst_sp_out", sp_out, 16'h0);
    reset_n = 1'b1;

    // Taken CALL NZ
    run_call(8'hC4, 16'h1000, 16'h8000, 8'h00, 0, 1'b0, lat, base);
    check("nz_lat", lat, 5);
    check("nz_taken", taken, 1'b1);
    check("nz_illegal", illegal, 1'b0);
    check("nz_ip_out", ip_out, 16'h1234);
    check("nz_sp_out", sp_out, 16'h7FFE);
    check("nz_nxfer", log_n - base, 4);
    chk_xfer("nz_x0", base + 0, 1'b0, 16'h1001, 8'h34);
    chk_xfer("nz_x1", base + 1, 1'b0, 16'h1002, 8'h12);
    chk_xfer("nz_x2", base + 2, 1'b1, 16'h7FFF, 8'h10);
    chk_xfer("nz_x3", base + 3, 1'b1, 16'h7FFE, 8'h03);

    // Not-taken CALL Z
    run_call(8'hCC, 16'h1000, 16'h8000, 8'h00, 0, 1'b0, lat, base);
    check("z_lat", lat, 3);
    check("z_taken", taken, 1'b0);
    check("z_ip_out", ip_out, 16'h1003);
    check("z_sp_out", sp_out, 16'h8000);
    check("z_nxfer", log_n - base, 2);
    chk_xfer("z_x0", base + 0, 1'b0, 16'h1001, 8'h34);
    chk_xfer("z_x1", base + 1, 1'b0, 16'h1002, 8'h12);

    // Unconditional CALL with IP and SP wrap
    run_call(8'hCD, 16'hFFFE, 16'h0000, 8'hFF, 0, 1'b0, lat, base);
    check("wrap_lat", lat, 5);
    check("wrap_taken", taken, 1'b1);
    check("wrap_ip_out", ip_out, 16'h55AA);
    check("wrap_sp_out", sp_out, 16'hFFFE);
    check("wrap_nxfer", log_n - base, 4);
    chk_xfer("wrap_x0", base + 0, 1'b0, 16'hFFFF, 8'hAA);
    chk_xfer("wrap_x1", base + 1, 1'b0, 16'h0000, 8'h55);
    chk_xfer("wrap_x2", base + 2, 1'b1, 16'hFFFF, 8'h00);
    chk_xfer("wrap_x3", base + 3, 1'b1, 16'hFFFE, 8'h01);

    // CALL M with two wait states per transfer and a start poke while busy
    run_call(8'hFC, 16'h2000, 16'h4000, 8'h80, 2, 1'b1, lat, base);
    check("m_lat", lat, 13);
    check("m_taken", taken, 1'b1);
    check("m_illegal", illegal, 1'b0);
    check("m_ip_out", ip_out, 16'h5678);
    check("m_sp_out", sp_out, 16'h3FFE);
    check("m_nxfer", log_n - base, 4);
    chk_xfer("m_x2", base + 2, 1'b1, 16'h3FFF, 8'h20);
    chk_xfer("m_x3", base + 3, 1'b1, 16'h3FFE, 8'h03);

    // Every condition under two flag patterns, SP=0001 wraps the second push
    for (int fi = 0; fi < 2; fi++) begin
      for (int c = 0; c < 8; c++) begin
        op = {2'b11, c[2:0], 3'b100};
        fv = (fi == 1) ? 8'hC5 : 8'h00;
        exp_tk = (fi == 1) ? tk_c5[c] : tk_00[c];
        run_call(op, 16'h1000, 16'h0001, fv, 0, 1'b0, lat, base);
        check("cc_taken", taken, exp_tk);
        check("cc_illegal", illegal, 1'b0);
        check("cc_lat", lat, exp_tk ? 5 : 3);
        check("cc_nxfer", log_n - base, exp_tk ? 4 : 2);
        check("cc_ip_out", ip_out, exp_tk ? 16'h1234 : 16'h1003);
        check("cc_sp_out", sp_out, exp_tk ? 16'hFFFF : 16'h0001);
        if (exp_tk) begin
          chk_xfer("cc_x2", base + 2, 1'b1, 16'h0000, 8'h10);
          chk_xfer("cc_x3", base + 3, 1'b1, 16'hFFFF, 8'h03);
        end
      end
    end

    // Illegal opcode
    run_call(8'h00, 16'h4321, 16'h1234, 8'h00, 0, 1'b0, lat, base);
    check("ill_lat", lat, 1);
    check("ill_illegal", illegal, 1'b1);
    check("ill_taken", taken, 1'b0);
    check("ill_ip_out", ip_out, 16'h4321);
    check("ill_sp_out", sp_out, 16'h1234);
    check("ill_nxfer", log_n - base, 0);

    // Reset while the low return byte is being written
    wait_states = 1;
    base = log_n;
    @(negedge clk);
    opcode = 8'hC4; ip_in = 16'h1000; sp_in = 16'h8000; f_in = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (log_n - base < 3 && cyc < 50) begin
      @(negedge clk);
      cyc = cyc + 1;
    end
    check("rstm_reached", log_n - base, 3);
    check("rstm_req_before", mem_req, 1'b1);
    reset_n = 1'b0;
    #1;
    check("rstm_mem_req", mem_req, 1'b0);
    check("rstm_mem_we", mem_we, 1'b0);
    check("rstm_mem_addr", mem_addr, 16'h0);
    check("rstm_mem_wdata", mem_wdata, 8'h0);
    check("rstm_busy", busy, 1'b0);
    check("rstm_taken", taken, 1'b0);
    check("rstm_illegal", illegal, 1'b0);
    check("rstm_ip_out", ip_out, 16'h0);
    check("rstm_sp_out", sp_out, 16'h0);
    repeat (3) begin
      @(negedge clk);
      check("rstm_no_done", done, 1'b0);
    end
    check("rstm_nxfer", log_n - base, 3);
    chk_xfer("rstm_x2", base + 2, 1'b1, 16'h7FFF, 8'h10);
    reset_n = 1'b1;

    run_call(8'hC4, 16'h1000, 16'h8000, 8'h00, 0, 1'b0, lat, base);
    check("post_lat", lat, 5);
    check("post_taken", taken, 1'b1);
    check("post_ip_out", ip_out, 16'h1234);
    check("post_sp_out", sp_out, 16'h7FFE);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
